// File: rtl/lcd_video_pkg.sv
`default_nettype none
// lcd_video_pkg: shared widths, coordinate/pixel types and receiver FSM encoding. Rev 1.0
package lcd_video_pkg;

  localparam int COORD_W = 11;
  localparam int RGB_W   = 16;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [RGB_W-1:0]   rgb_t;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_WAIT   = 2'd1,
    ST_FRAME  = 2'd2
  } rx_state_t;

  function automatic coord_t coord_inc(input coord_t v, input coord_t vmax);
    return (v >= vmax) ? vmax : coord_t'(v + 1'b1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_rgb_rx_if.sv
`default_nettype none
// lcd_rgb_rx_if: recovered pixel stream (pixel, coordinates, line/frame strobes). Rev 1.0
interface lcd_rgb_rx_if;
  import lcd_video_pkg::*;

  logic   pix_valid;
  rgb_t   pix_data;
  coord_t pix_x;
  coord_t pix_y;
  logic   frame_start;
  logic   line_end;
  logic   frame_end;

  modport master (output pix_valid, pix_data, pix_x, pix_y, frame_start, line_end, frame_end);
  modport slave  (input  pix_valid, pix_data, pix_x, pix_y, frame_start, line_end, frame_end);

endinterface
`default_nettype wire

// File: rtl/lcd_blank_detect.sv
`default_nettype none
// lcd_blank_detect: DE-low run counter plus DE rise, last-pixel and vertical-blank strobes. Rev 1.0
module lcd_blank_detect #(
  parameter logic [11:0] VBLANK_MIN = 12'd2048
) (
  input  logic lcd_clk,
  input  logic sys_rst_n,
  input  logic i_de_pin,
  input  logic i_de,
  output logic o_de_rise,
  output logic o_last,
  output logic o_vblank
);

  logic [11:0] r_idle;
  logic        r_de_d;

  always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_idle <= '0;
      r_de_d <= 1'b0;
    end else begin
      r_de_d <= i_de;
      if (i_de)
        r_idle <= '0;
      else if (r_idle != VBLANK_MIN)
        r_idle <= r_idle + 12'd1;
    end
  end

  // The raw pin is one cycle ahead of i_de, so it marks the last pixel before DE falls.
  assign o_de_rise = i_de & ~r_de_d;
  assign o_last    = i_de & ~i_de_pin;
  assign o_vblank  = ~i_de & (r_idle == VBLANK_MIN - 12'd1);

endmodule
`default_nettype wire

// File: rtl/lcd_rgb_rx.sv
`default_nettype none
// lcd_rgb_rx: DE-only RGB565 receiver -- pixel/coordinate recovery, geometry measurement, lock. Rev 1.0
// Defining LCD_RGB_RX_SUM_EN adds the frame_sum output (mod-2^16 sum of each frame's pixels).
module lcd_rgb_rx
  import lcd_video_pkg::*;
#(
  parameter logic [11:0] VBLANK_MIN  = 12'd2048,
  parameter logic [2:0]  LOCK_FRAMES = 3'd2,
  parameter coord_t      COORD_MAX   = 11'd2047
) (
  input  logic         lcd_clk,
  input  logic         sys_rst_n,
  input  logic         lcd_de,
  input  rgb_t         lcd_rgb,
  lcd_rgb_rx_if.master pix,
  output coord_t       meas_width,
  output coord_t       meas_height,
  output logic         locked,
  output logic         timing_err
`ifdef LCD_RGB_RX_SUM_EN
  ,
  output rgb_t         frame_sum
`endif
);

  logic      r_de;
  rgb_t      r_rgb;
  rx_state_t r_state;
  coord_t    r_xcnt, r_ycnt, r_w0;
  logic      r_xfull, r_xerr, r_yfull, r_yerr, r_l0done, r_ferr, r_first;
  logic [2:0] r_match;

  logic      w_de_rise, w_last, w_vblank;
  logic      w_pix, w_fs, w_is_line0, w_xsat_err, w_ysat_err, w_wmis, w_lerr, w_fe_ok;
  coord_t    w_y, w_width;
  logic [2:0] w_match_inc;

  always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_de  <= 1'b0;
      r_rgb <= '0;
    end else begin
      r_de  <= lcd_de;
      r_rgb <= lcd_rgb;
    end
  end

  lcd_blank_detect #(.VBLANK_MIN(VBLANK_MIN)) u_blank (
    .lcd_clk   (lcd_clk),
    .sys_rst_n (sys_rst_n),
    .i_de_pin  (lcd_de),
    .i_de      (r_de),
    .o_de_rise (w_de_rise),
    .o_last    (w_last),
    .o_vblank  (w_vblank)
  );

  always_comb begin
    w_pix       = r_de && (r_state != ST_SEARCH);
    w_fs        = (r_state == ST_WAIT) && w_de_rise;
    w_y         = w_fs ? '0 : r_ycnt;
    w_is_line0  = w_fs || !r_l0done;
    w_width     = coord_inc(r_xcnt, COORD_MAX);
    // A pixel is "saturating" only once the coordinate is already pinned at COORD_MAX.
    w_xsat_err  = w_pix && (r_xcnt == COORD_MAX) && r_xfull && !r_xerr;
    w_ysat_err  = w_pix && !w_fs && (r_xcnt == '0) && r_yfull && !r_yerr;
    w_wmis      = w_pix && w_last && !w_is_line0 && (w_width != r_w0);
    w_lerr      = w_xsat_err || w_ysat_err || w_wmis;
    w_fe_ok     = !r_ferr && (r_first || ((r_w0 == meas_width) && (r_ycnt == meas_height)));
    w_match_inc = (r_match == 3'd7) ? 3'd7 : r_match + 3'd1;
  end

  always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state         <= ST_SEARCH;
      r_xcnt          <= '0;
      r_ycnt          <= '0;
      r_w0            <= '0;
      r_xfull         <= 1'b0;
      r_xerr          <= 1'b0;
      r_yfull         <= 1'b0;
      r_yerr          <= 1'b0;
      r_l0done        <= 1'b0;
      r_ferr          <= 1'b0;
      r_first         <= 1'b0;
      r_match         <= '0;
      pix.pix_valid   <= 1'b0;
      pix.pix_data    <= '0;
      pix.pix_x       <= '0;
      pix.pix_y       <= '0;
      pix.frame_start <= 1'b0;
      pix.line_end    <= 1'b0;
      pix.frame_end   <= 1'b0;
      meas_width      <= '0;
      meas_height     <= '0;
      locked          <= 1'b0;
      timing_err      <= 1'b0;
    end else begin
      pix.pix_valid   <= 1'b0;
      pix.frame_start <= 1'b0;
      pix.line_end    <= 1'b0;
      pix.frame_end   <= 1'b0;
      timing_err      <= 1'b0;

      case (r_state)
        ST_SEARCH: if (w_vblank) begin
          r_state <= ST_WAIT;
          r_first <= 1'b1;
        end
        ST_WAIT: if (w_de_rise) r_state <= ST_FRAME;
        ST_FRAME: if (w_vblank) begin
          r_state       <= ST_WAIT;
          r_first       <= 1'b0;
          pix.frame_end <= 1'b1;
          meas_width    <= r_w0;
          meas_height   <= r_ycnt;
          if (w_fe_ok) begin
            r_match <= w_match_inc;
            if (w_match_inc >= LOCK_FRAMES) locked <= 1'b1;
          end else begin
            timing_err <= 1'b1;
            locked     <= 1'b0;
            r_match    <= r_ferr ? 3'd0 : 3'd1;
          end
        end
        default: r_state <= ST_SEARCH;
      endcase

      if (w_pix) begin
        pix.pix_valid   <= 1'b1;
        pix.pix_data    <= r_rgb;
        pix.pix_x       <= r_xcnt;
        pix.pix_y       <= w_y;
        pix.frame_start <= w_fs;
        pix.line_end    <= w_last;
        if (w_fs) begin
          r_ferr   <= 1'b0;
          r_yfull  <= 1'b0;
          r_yerr   <= 1'b0;
          r_l0done <= 1'b0;
          r_ycnt   <= '0;
        end
        if (r_xcnt == COORD_MAX) r_xfull <= 1'b1;
        if (w_xsat_err) r_xerr <= 1'b1;
        if (w_ysat_err) r_yerr <= 1'b1;
        if (w_last) begin
          r_xcnt   <= '0;
          r_xfull  <= 1'b0;
          r_xerr   <= 1'b0;
          r_l0done <= 1'b1;
          r_ycnt   <= coord_inc(w_y, COORD_MAX);
          if (w_is_line0) r_w0 <= w_width;
          if (w_y == COORD_MAX) r_yfull <= 1'b1;
        end else begin
          r_xcnt <= coord_inc(r_xcnt, COORD_MAX);
        end
        if (w_lerr) begin
          timing_err <= 1'b1;
          locked     <= 1'b0;
          r_ferr     <= 1'b1;
        end
      end
    end
  end

`ifdef LCD_RGB_RX_SUM_EN
  rgb_t r_sum;

  always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_sum     <= '0;
      frame_sum <= '0;
    end else begin
      if (w_pix) r_sum <= w_fs ? r_rgb : rgb_t'(r_sum + r_rgb);
      if ((r_state == ST_FRAME) && w_vblank) frame_sum <= r_sum;
    end
  end
`endif

endmodule
`default_nettype wire
